sq_sprite_renderer: RTL and testbench
=====================================

Name: sq_sprite_renderer

Overview:
- Parametrised successor to the square pixel generator. Renders N_SQ obstacle squares plus one player ("main") square over a background colour for the VGA pixel stream.
- Adds frame-synchronous shadow registers, so position updates never tear mid-frame, and a per-square enable mask.
- Uses a fixed 2-cycle compare/priority pipeline and reports per-frame main-vs-obstacle collisions.
- Sits between the game-logic position bus and the VGA RGB output, clocked by the 100 MHz system clock.

Parameters:
- N_SQ, 16, number of obstacle squares (1..32)
- COORD_W, 10, width of one x or y coordinate
- SQ_SIZE, 30, side length in pixels of every square (1..2^COORD_W-1)
- COLOR_W, 12, RGB width
- SQ_RGB, 12'h00F, obstacle colour
- MAIN_RGB, 12'h0FF, main-square colour
- BG_RGB, 12'hF00, background colour
- BORDER_RGB, 12'hFFF, border colour (used only with SQ_BORDER_EN)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- video_on  in  1  active display region
- x  in  COORD_W  current pixel column
- y  in  COORD_W  current pixel row
- frame_start  in  1  one-cycle pulse at start of vertical blank; commit point for shadow registers
- position  in  (N_SQ+1)*2*COORD_W  per square i: [i*2W +: W]=x_left, [i*2W+W +: W]=y_top; index N_SQ is the main square
- sq_en  in  N_SQ  obstacle enable mask; bit i enables square i
- rgb  out  COLOR_W  pixel colour, registered
- hit_valid  out  1  registered; 1 when output pixel lies on any enabled obstacle
- hit_idx  out  clog2(N_SQ)  registered; lowest-index obstacle covering the pixel (0 when hit_valid=0)
- collision  out  1  one-cycle pulse, 1 cycle after frame_start, if the previous frame had a collision

Behaviour:
- Reset (reset==0 at posedge): rgb=0, hit_valid=0, hit_idx=0, collision=0; all shadow positions=0, shadow sq_en=0, collision accumulator cleared, pipeline valid bits cleared. Reset mid-frame: outputs show black from the next cycle until video_on propagates again.
- Shadow update: on a cycle with frame_start=1, shadow position and shadow sq_en load from the inputs. Otherwise they hold. Rendering uses shadow values only; input changes mid-frame have no visible effect until the next frame_start.
- Stage 1 (cycle t+1):
  - For each square, compute right edge = x_left+SQ_SIZE-1 and bottom edge = y_top+SQ_SIZE-1 in COORD_W+1 bits; no wrap.
  - A square at x_left=1020 with SQ_SIZE=30 covers columns 1020..1023 only.
  - Inside test is inclusive on all four edges.
  - Register per-square hit vector (masked by shadow sq_en), main-hit bit, and delayed video_on.
- Stage 2 (cycle t+2):
  - Priority encode the hit vector, lowest index wins.
  - rgb = 0 if delayed video_on==0; else SQ_RGB if any obstacle hit; else MAIN_RGB if main hit; else BG_RGB.
  - hit_valid/hit_idx are registered alongside rgb and forced to 0 when video_on==0.
- Latency: x, y, video_on sampled at cycle t produce rgb at cycle t+2 exactly, for every pixel including the first after reset.
- Collision accumulator: set when, in stage 2, video_on==1, main hit==1 and any obstacle hit==1. On frame_start, the accumulator value is copied to a pending flag and the accumulator is cleared. collision pulses high for exactly 1 cycle, the cycle after frame_start.
- frame_start coinciding with a stage-2 overlap cycle: that overlap counts toward the frame being closed.
- Back-to-back frame_start pulses (2 consecutive cycles): second reports the (empty) interval → collision=0 on second pulse.
- Main square is always drawn (no enable). Disabled obstacles never hit, colour, or collide.

Optional Feature:
- Macro: SQ_BORDER_EN.
- Defined: a pixel on an obstacle whose x equals x_left or right edge, or whose y equals y_top or bottom edge, outputs BORDER_RGB instead of SQ_RGB. hit_valid and hit_idx are unchanged. Latency remains 2 cycles (edge flags computed in stage 1).
- Not defined: obstacles are solid SQ_RGB and no border logic is synthesised.

Test Plan:
- Reset then video_on=1, x=y=5, all shadows 0, sq_en=0 → main square at (0,0) covers pixel → rgb=12'h0FF at t+2; hit_valid=0.
- Square 3 at (100,50), sq_en=0x0008, frame_start pulse; scan x=100,129,130 at y=50 → rgb F00→00F,00F,F00 pattern: 00F,00F,F00, hit_idx=3 for first two.
- Squares 2 and 5 both at (200,200), enabled; pixel (210,210) → rgb=00F, hit_idx=2.
- Change position of square 0 mid-frame without frame_start → rendered pixels unchanged; after frame_start new location drawn.
- Main at (300,300) overlapping enabled square 1 at (310,310); run a frame, then frame_start → collision=1 for exactly the cycle after frame_start; next frame with no overlap → collision=0.
- Square at x_left=1020: pixels x=1023 hit, x=0..18 same row no hit (no wrap); reset=0 asserted mid-line → rgb=0 next cycle.

Source files
------------

// File: rtl/sq_sprite_renderer_if.sv
// ---------------------------------------------------------------------------
// sq_sprite_renderer_if
//   Pixel-stream and position bus between the game logic / VGA timing
//   (master) and the square sprite renderer (slave).
//
//   Master -> slave : video_on, x, y, frame_start, position, sq_en
//   Slave -> master : rgb, hit_valid, hit_idx, collision
//
//   position packs N_SQ+1 squares; square i occupies
//   [i*2*COORD_W +: COORD_W] = x_left and [i*2*COORD_W+COORD_W +: COORD_W] = y_top.
//   Index N_SQ is the player (main) square.
// ---------------------------------------------------------------------------
interface sq_sprite_renderer_if #(
  parameter int N_SQ    = 16,
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12
);
  localparam int IDX_W = (N_SQ > 1) ? $clog2(N_SQ) : 1;

  logic                            video_on;
  logic [COORD_W-1:0]              x;
  logic [COORD_W-1:0]              y;
  logic                            frame_start;
  logic [(N_SQ+1)*2*COORD_W-1:0]   position;
  logic [N_SQ-1:0]                 sq_en;
  logic [COLOR_W-1:0]              rgb;
  logic                            hit_valid;
  logic [IDX_W-1:0]                hit_idx;
  logic                            collision;

  modport master (
    output video_on, x, y, frame_start, position, sq_en,
    input  rgb, hit_valid, hit_idx, collision
  );

  modport slave (
    input  video_on, x, y, frame_start, position, sq_en,
    output rgb, hit_valid, hit_idx, collision
  );
endinterface

// File: rtl/sq_sprite_renderer.sv
// ---------------------------------------------------------------------------
// sq_sprite_renderer
//   Draws N_SQ obstacle squares and one always-visible main square over a
//   background colour. Square positions and the enable mask are captured in
//   shadow registers on frame_start so updates never tear mid-frame.
//   Two-stage pipeline: stage 1 registers per-square inside tests, stage 2
//   priority-encodes (lowest index wins) and registers the pixel colour.
//   Main-vs-obstacle overlaps are accumulated per frame and reported as a
//   one-cycle collision pulse the cycle after frame_start.
//
//   Ports:
//     clk    - system clock (100 MHz)
//     reset  - synchronous, active-low reset
//     bus    - sq_sprite_renderer_if.slave (pixel stream in, colour/hit out)
//
//   Optional feature: define SQ_BORDER_EN to draw a BORDER_RGB outline on
//   the edge pixels of obstacles. Undefined: solid obstacles, no edge logic.
// ---------------------------------------------------------------------------
module sq_sprite_renderer #(
  parameter int                 N_SQ       = 16,
  parameter int                 COORD_W    = 10,
  parameter int                 SQ_SIZE    = 30,
  parameter int                 COLOR_W    = 12,
  parameter logic [COLOR_W-1:0] SQ_RGB     = 12'h00F,
  parameter logic [COLOR_W-1:0] MAIN_RGB   = 12'h0FF,
  parameter logic [COLOR_W-1:0] BG_RGB     = 12'hF00,
  parameter logic [COLOR_W-1:0] BORDER_RGB = 12'hFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  sq_sprite_renderer_if.slave   bus
);
  localparam int IDX_W = (N_SQ > 1) ? $clog2(N_SQ) : 1;
  localparam int PW    = (N_SQ + 1) * 2 * COORD_W;
  // One extra bit so right/bottom edges past the screen never wrap to 0.
  localparam int EW    = COORD_W + 1;
  localparam logic [EW-1:0] SPAN = EW'(SQ_SIZE - 1);

  logic [PW-1:0]       sh_pos;
  logic [N_SQ-1:0]     sh_en;
  logic [N_SQ-1:0]     hit_c, s1_hit;
  logic                main_c, s1_main, s1_vid;
  logic [IDX_W-1:0]    idx_c;
  logic [COLOR_W-1:0]  obs_rgb, rgb_c;
  logic                overlap, acc;

  function automatic logic covers(input logic [COORD_W-1:0] left, top, px, py);
    logic [EW-1:0] right, bottom;
    right  = {1'b0, left} + SPAN;
    bottom = {1'b0, top}  + SPAN;
    return ({1'b0, px} >= {1'b0, left}) && ({1'b0, px} <= right) &&
           ({1'b0, py} >= {1'b0, top})  && ({1'b0, py} <= bottom);
  endfunction

  // Stage 1 combinational: inside tests against the shadow positions.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < N_SQ; i++) begin
      hit_c[i] = sh_en[i] & covers(sh_pos[i*2*COORD_W +: COORD_W],
                                   sh_pos[i*2*COORD_W+COORD_W +: COORD_W],
                                   bus.x, bus.y);
    end
    main_c = covers(sh_pos[N_SQ*2*COORD_W +: COORD_W],
                    sh_pos[N_SQ*2*COORD_W+COORD_W +: COORD_W],
                    bus.x, bus.y);
  end

`ifdef SQ_BORDER_EN
  logic [N_SQ-1:0] edge_c, s1_edge;

  function automatic logic on_edge(input logic [COORD_W-1:0] left, top, px, py);
    logic [EW-1:0] right, bottom;
    right  = {1'b0, left} + SPAN;
    bottom = {1'b0, top}  + SPAN;
    return (px == left) || ({1'b0, px} == right) ||
           (py == top)  || ({1'b0, py} == bottom);
  endfunction

  always_comb begin
    edge_c = '0;
    for (int i = 0; i < N_SQ; i++) begin
      edge_c[i] = on_edge(sh_pos[i*2*COORD_W +: COORD_W],
                          sh_pos[i*2*COORD_W+COORD_W +: COORD_W],
                          bus.x, bus.y);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) s1_edge <= '0;
    else        s1_edge <= edge_c;
  end
`endif

  // Stage 2 combinational: lowest-index obstacle wins; colour select.
  always_comb begin
    idx_c = '0;
    for (int i = N_SQ - 1; i >= 0; i--) begin
      if (s1_hit[i]) idx_c = IDX_W'(i);
    end
    obs_rgb = SQ_RGB;
`ifdef SQ_BORDER_EN
    if (s1_edge[idx_c]) obs_rgb = BORDER_RGB;
`endif
    if (!s1_vid)         rgb_c = '0;
    else if (|s1_hit)    rgb_c = obs_rgb;
    else if (s1_main)    rgb_c = MAIN_RGB;
    else                 rgb_c = BG_RGB;
  end

  assign overlap = s1_vid & s1_main & (|s1_hit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: shadow positions are reset on purpose: the main square must
      // render at the origin before the first frame_start.
      sh_pos        <= '0;
      sh_en         <= '0;
      s1_hit        <= '0;
      s1_main       <= 1'b0;
      s1_vid        <= 1'b0;
      bus.rgb       <= '0;
      bus.hit_valid <= 1'b0;
      bus.hit_idx   <= '0;
      bus.collision <= 1'b0;
      acc           <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        sh_pos <= bus.position;
        sh_en  <= bus.sq_en;
      end
      s1_hit        <= hit_c;
      s1_main       <= main_c;
      s1_vid        <= bus.video_on;
      bus.rgb       <= rgb_c;
      bus.hit_valid <= s1_vid & (|s1_hit);
      bus.hit_idx   <= s1_vid ? idx_c : '0;
      // An overlap in stage 2 on the frame_start cycle closes with the old frame.
      if (bus.frame_start) begin
        bus.collision <= acc | overlap;
        acc           <= 1'b0;
      end else begin
        bus.collision <= 1'b0;
        acc           <= acc | overlap;
      end
    end
  end
endmodule

// File: tb/tb_sq_sprite_renderer.sv
// ---------------------------------------------------------------------------
// tb_sq_sprite_renderer
//   Self-checking bench: directed scenarios followed by randomized pixel,
//   position, enable, frame_start and reset stimulus, all compared against a
//   behavioural model of the renderer kept in this file.
// ---------------------------------------------------------------------------
module tb_sq_sprite_renderer;
  localparam int N_SQ    = 16;
  localparam int COORD_W = 10;
  localparam int SQ_SIZE = 30;
  localparam int COLOR_W = 12;
  localparam logic [11:0] SQ_C     = 12'h00F;
  localparam logic [11:0] MAIN_C   = 12'h0FF;
  localparam logic [11:0] BG_C     = 12'hF00;
  localparam logic [11:0] BORDER_C = 12'hFFF;
`ifdef SQ_BORDER_EN
  localparam logic [11:0] EDGE_C = BORDER_C;
`else
  localparam logic [11:0] EDGE_C = SQ_C;
`endif

  typedef struct {
    logic [11:0] rgb;
    bit          hv;
    int          idx;
    bit          ov;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  sq_sprite_renderer_if #(.N_SQ(N_SQ), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) bus ();

  sq_sprite_renderer #(
    .N_SQ(N_SQ), .COORD_W(COORD_W), .SQ_SIZE(SQ_SIZE), .COLOR_W(COLOR_W),
    .SQ_RGB(SQ_C), .MAIN_RGB(MAIN_C), .BG_RGB(BG_C), .BORDER_RGB(BORDER_C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int              pos_x [N_SQ+1];
  int              pos_y [N_SQ+1];
  logic [N_SQ-1:0] en_in;
  int              sh_x  [N_SQ+1];
  int              sh_y  [N_SQ+1];
  logic [N_SQ-1:0] sh_en;
  exp_t            exp_q [$];
  int              frame_hits;
  int              n_checks;
  int              n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_sq(int l, int t, int px, int py);
    return px >= l && px <= l + SQ_SIZE - 1 && py >= t && py <= t + SQ_SIZE - 1;
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.rgb = '0; e.hv = 0; e.idx = 0; e.ov = 0;
    return e;
  endfunction

  // What the screen should show for one pixel, given the committed frame.
  function automatic exp_t model(bit vid, int px, int py);
    exp_t e;
    int   win;
    bit   main_hit;
    e   = blank();
    win = -1;
    for (int i = 0; i < N_SQ; i++)
      if (win < 0 && sh_en[i] && in_sq(sh_x[i], sh_y[i], px, py)) win = i;
    main_hit = in_sq(sh_x[N_SQ], sh_y[N_SQ], px, py);
    if (!vid) return e;
    if (win >= 0) begin
      e.hv  = 1;
      e.idx = win;
      e.rgb = SQ_C;
`ifdef SQ_BORDER_EN
      if (px == sh_x[win] || px == sh_x[win] + SQ_SIZE - 1 ||
          py == sh_y[win] || py == sh_y[win] + SQ_SIZE - 1) e.rgb = BORDER_C;
`endif
    end else begin
      e.rgb = main_hit ? MAIN_C : BG_C;
    end
    e.ov = main_hit && (win >= 0);
    return e;
  endfunction

  // One clock: present inputs, advance the model, check the pixel issued
  // on the previous step (two-cycle latency) and the collision pulse.
  task automatic step(input bit fs);
    exp_t prev, cur;
    bit   exp_coll;
    bus.frame_start = fs;
    bus.sq_en       = en_in;
    for (int i = 0; i <= N_SQ; i++) begin
      bus.position[i*2*COORD_W +: COORD_W]         = COORD_W'(pos_x[i]);
      bus.position[i*2*COORD_W+COORD_W +: COORD_W] = COORD_W'(pos_y[i]);
    end
    if (!reset) begin
      exp_q.delete();
      prev       = blank();
      cur        = blank();
      exp_coll   = 0;
      frame_hits = 0;
      sh_en      = '0;
      for (int i = 0; i <= N_SQ; i++) begin sh_x[i] = 0; sh_y[i] = 0; end
    end else begin
      if (exp_q.size() > 0) prev = exp_q.pop_front();
      else                  prev = blank();
      if (prev.ov) frame_hits++;
      exp_coll = fs && (frame_hits > 0);
      if (fs) frame_hits = 0;
      cur = model(bus.video_on, int'(bus.x), int'(bus.y));
      if (fs) begin
        sh_en = en_in;
        for (int i = 0; i <= N_SQ; i++) begin sh_x[i] = pos_x[i]; sh_y[i] = pos_y[i]; end
      end
    end
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
    check("rgb",       32'(bus.rgb),       32'(prev.rgb));
    check("hit_valid", 32'(bus.hit_valid), 32'(prev.hv));
    check("hit_idx",   32'(bus.hit_idx),   32'(prev.idx));
    check("collision", 32'(bus.collision), 32'(exp_coll));
  endtask

  task automatic drive(input bit vid, input int px, input int py, input bit fs);
    bus.video_on = vid;
    bus.x        = COORD_W'(px);
    bus.y        = COORD_W'(py);
    step(fs);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    frame_hits = 0;
    en_in = '0;
    sh_en = '0;
    for (int i = 0; i <= N_SQ; i++) begin pos_x[i] = 0; pos_y[i] = 0; sh_x[i] = 0; sh_y[i] = 0; end
    bus.video_on = 0; bus.x = '0; bus.y = '0; bus.frame_start = 0;
    bus.position = '0; bus.sq_en = '0;

    // Reset, then main square at the origin covers (5,5).
    reset = 0;
    repeat (3) drive(0, 0, 0, 0);
    reset = 1;
    drive(1, 5, 5, 0);
    drive(0, 0, 0, 0);
    check("main_at_origin", 32'(bus.rgb), 32'(MAIN_C));
    check("main_no_hit", 32'(bus.hit_valid), 32'd0);

    // Square 3 at (100,50): left edge, right edge, one past.
    pos_x[N_SQ] = 600; pos_y[N_SQ] = 400;
    pos_x[3] = 100; pos_y[3] = 50;
    en_in = 16'h0008;
    drive(0, 0, 0, 1);
    drive(1, 100, 50, 0);
    drive(1, 129, 50, 0);
    check("left_edge_rgb", 32'(bus.rgb), 32'(EDGE_C));
    check("left_edge_idx", 32'(bus.hit_idx), 32'd3);
    drive(1, 130, 50, 0);
    check("right_edge_rgb", 32'(bus.rgb), 32'(EDGE_C));
    check("right_edge_idx", 32'(bus.hit_idx), 32'd3);
    drive(0, 0, 0, 0);
    check("past_right_rgb", 32'(bus.rgb), 32'(BG_C));
    check("past_right_hit", 32'(bus.hit_valid), 32'd0);

    // Squares 2 and 5 stacked: lowest index wins.
    pos_x[2] = 200; pos_y[2] = 200; pos_x[5] = 200; pos_y[5] = 200;
    en_in = 16'h002D;
    drive(0, 0, 0, 1);
    drive(1, 210, 210, 0);
    drive(0, 0, 0, 0);
    check("stack_rgb", 32'(bus.rgb), 32'(SQ_C));
    check("stack_idx", 32'(bus.hit_idx), 32'd2);

    // Mid-frame move of square 0 stays invisible until frame_start.
    pos_x[0] = 400; pos_y[0] = 100;
    drive(1, 405, 105, 0);
    drive(1, 5, 5, 0);
    check("stale_new_loc", 32'(bus.rgb), 32'(BG_C));
    drive(0, 0, 0, 0);
    check("stale_old_loc", 32'(bus.rgb), 32'(SQ_C));
    drive(0, 0, 0, 1);
    drive(1, 405, 105, 0);
    drive(0, 0, 0, 0);
    check("moved_loc", 32'(bus.rgb), 32'(SQ_C));

    // Collision: main (300,300) overlapping square 1 at (310,310).
    pos_x[N_SQ] = 300; pos_y[N_SQ] = 300;
    pos_x[1] = 310; pos_y[1] = 310;
    en_in = 16'h0002;
    drive(0, 0, 0, 1);
    drive(1, 315, 315, 0);
    drive(1, 320, 320, 0);
    drive(1, 50, 50, 0);
    drive(0, 0, 0, 1);
    check("collision_pulse", 32'(bus.collision), 32'd1);
    drive(0, 0, 0, 0);
    check("collision_one_cycle", 32'(bus.collision), 32'd0);
    drive(1, 305, 305, 0);
    drive(1, 335, 335, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    check("no_collision_frame", 32'(bus.collision), 32'd0);
    // Overlap in stage 2 on the frame_start cycle, then back-to-back pulse.
    drive(1, 315, 315, 0);
    drive(0, 0, 0, 1);
    check("overlap_at_close", 32'(bus.collision), 32'd1);
    drive(0, 0, 0, 1);
    check("back_to_back", 32'(bus.collision), 32'd0);

    // Right screen edge: no wrap to column 0.
    pos_x[4] = 1020; pos_y[4] = 600;
    en_in = 16'h0010;
    drive(0, 0, 0, 1);
    drive(1, 1023, 600, 0);
    drive(1, 0, 600, 0);
    check("edge_1023_hit", 32'(bus.hit_valid), 32'd1);
    check("edge_1023_idx", 32'(bus.hit_idx), 32'd4);
    drive(1, 1, 600, 0);
    check("no_wrap_x0", 32'(bus.hit_valid), 32'd0);
    for (int px = 2; px <= 18; px++) drive(1, px, 600, 0);
    drive(1, 1022, 600, 0);
    reset = 0;
    drive(1, 1023, 600, 0);
    check("reset_black", 32'(bus.rgb), 32'd0);
    reset = 1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int i = 0; i <= N_SQ; i++) begin
          pos_x[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 120);
          pos_y[i] = $urandom_range(0, 120);
        end
      end
      if ($urandom_range(0, 49) == 0) en_in = N_SQ'($urandom);
      reset = ($urandom_range(0, 499) != 0);
      drive($urandom_range(0, 7) != 0,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 160),
            $urandom_range(0, 160),
            $urandom_range(0, 39) == 0);
    end
    reset = 1;
    repeat (3) drive(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
